// File: rtl/cm0_ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package cm0_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/cm0_ahb_lanes.sv
// Size/address to byte-lane enables plus a natural-alignment flag.
// Sizes wider than a word collapse to a full-word access.
module cm0_ahb_lanes
    import cm0_ahb_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [1:0] i_addr,
    output logic [3:0] o_lanes,
    output logic       o_misalign
);

    always_comb begin
        o_lanes    = 4'hF;
        o_misalign = 1'b0;
        case (i_size)
            HSIZE_BYTE: o_lanes = 4'b0001 << i_addr;
            HSIZE_HALF: begin
                o_lanes    = i_addr[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr[0];
            end
            HSIZE_WORD: o_misalign = |i_addr;
            default: ;
        endcase
    end

endmodule

// File: rtl/cm0_ahb_sram_slv.sv
// AHB-Lite SRAM slave with WAIT wait states per data phase.
// Define CM0_AHB_SRAM_ERR_EN to answer illegal transfers with a two-cycle ERROR.
module cm0_ahb_sram_slv
    import cm0_ahb_pkg::*;
#(
    parameter int AW   = 12,
    parameter int WAIT = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [1:0] WAIT_CNT = 2'(WAIT);

    logic          w_accept;
    logic          w_illegal;
    logic          w_misalign;
    logic          w_final;
    logic [3:0]    w_lanes;
    logic          w_unused;

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic          r_active;
    logic          r_write;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_lanes;
    logic          r_hreadyout;
    logic          r_hresp;
    logic [31:0]   r_mem [2**AW];

    cm0_ahb_lanes u_lanes (
        .i_size     (HSIZE),
        .i_addr     (HADDR[1:0]),
        .o_lanes    (w_lanes),
        .o_misalign (w_misalign)
    );

    assign w_accept = HSEL & HTRANS[1] & HREADY;

`ifdef CM0_AHB_SRAM_ERR_EN
    assign w_illegal = (HSIZE > HSIZE_WORD) | w_misalign | (|HADDR[31:AW+2]);
`else
    assign w_illegal = 1'b0;
`endif

    // Without error checking the upper address bits simply wrap.
    assign w_unused = ^{HTRANS[0], HADDR[31:AW+2], w_misalign};

    // The OKAY data phase finishes in whichever cycle the slave reports ready.
    assign w_final = r_active & r_hreadyout;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_active    <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_lanes     <= 4'h0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else if (w_accept && w_illegal) begin
            r_state     <= ST_ERR1;
            r_active    <= 1'b0;
            r_hreadyout <= 1'b0;
            r_hresp     <= HRESP_ERROR;
        end else if (w_accept) begin
            r_active <= 1'b1;
            r_write  <= HWRITE;
            r_addr   <= HADDR[AW+1:2];
            r_lanes  <= w_lanes;
            r_hresp  <= HRESP_OKAY;
            if (WAIT == 0) begin
                r_state     <= ST_IDLE;
                r_hreadyout <= 1'b1;
            end else begin
                r_state     <= ST_WAIT;
                r_cnt       <= WAIT_CNT;
                r_hreadyout <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                ST_WAIT: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt       <= r_cnt - 2'd1;
                        r_hreadyout <= (r_cnt == 2'd1);
                    end else begin
                        r_state     <= ST_IDLE;
                        r_active    <= 1'b0;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_active    <= 1'b0;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Reset clears r_active, so an interrupted write never reaches the array.
    always_ff @(posedge HCLK) begin
        if (w_final && r_write) begin
            for (int b = 0; b < 4; b++) begin
                if (r_lanes[b]) r_mem[r_addr][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HRDATA    = (w_final && !r_write) ? r_mem[r_addr] : 32'd0;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;

endmodule

// File: tb/tb_cm0_ahb_sram_slv.sv
// Drives a zero-wait and a two-wait SRAM slave against a transaction-level memory model.
module tb_cm0_ahb_sram_slv;

    localparam int AW = 6;
    localparam int NW = 1 << AW;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  hsel;
    logic [1:0]  hwrite;
    logic [1:0]  hreadyout;
    logic [1:0]  hresp;
    logic [31:0] haddr  [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize  [2];

    int          waitc [2] = '{0, 2};
    logic [31:0] mem_m [2][NW];
    int          m_left [2];
    bit          m_err [2];
    bit          m_wr [2];
    int          m_word [2];
    logic [3:0]  m_lanes [2];
    logic [31:0] m_wdata [2];
    logic [31:0] last_rd [2];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    cm0_ahb_sram_slv #(.AW(AW), .WAIT(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HSIZE(hsize[0]), .HWRITE(hwrite[0]), .HWDATA(hwdata[0]),
        .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    cm0_ahb_sram_slv #(.AW(AW), .WAIT(2)) u_dut1 (
        .HCLK(clk), .HRESET(rst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HSIZE(hsize[1]), .HWRITE(hwrite[1]), .HWDATA(hwdata[1]),
        .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    function automatic xfer_t mk(input bit wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.wr = wr;
        x.addr = addr; x.size = size; x.wdata = wdata;
        return x;
    endfunction

    function automatic bit m_illegal(input xfer_t x);
`ifdef CM0_AHB_SRAM_ERR_EN
        int unsigned nb;
        if (x.size > 3'd2) return 1'b1;
        nb = 32'd1 << x.size;
        if ((x.addr % nb) != 0) return 1'b1;
        if (x.addr >= (32'd4 << AW)) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_lanes_of(input xfer_t x);
        int unsigned nb;
        int unsigned first;
        logic [3:0] l;
        nb = (x.size > 3'd2) ? 32'd4 : (32'd1 << x.size);
        first = ((x.addr % 4) / nb) * nb;
        l = 4'h0;
        for (int unsigned i = first; i < first + nb; i++) l[i] = 1'b1;
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle(input int d);
        hsel[d]   = 1'($urandom_range(0, 1));
        htrans[d] = 2'($urandom_range(0, 1));
        haddr[d]  = $urandom();
        hsize[d]  = 3'($urandom_range(0, 7));
        hwrite[d] = 1'($urandom_range(0, 1));
    endtask

    // One bus cycle: check this cycle's outputs, then drive the next address phase.
    task automatic cycle(input int d, input xfer_t x, input bit use_x, output bit took);
        logic        ex_rdy;
        logic        ex_rsp;
        logic [31:0] ex_dat;
        bit          ready;
        @(negedge clk);
        ex_rdy = 1'b1; ex_rsp = 1'b0; ex_dat = 32'd0;
        if (m_left[d] > 0) begin
            ex_rdy = (m_left[d] == 1);
            if (m_err[d]) ex_rsp = 1'b1;
            else if (m_left[d] == 1 && !m_wr[d]) ex_dat = mem_m[d][m_word[d]];
        end
        chk($sformatf("hreadyout%0d", d), 32'(hreadyout[d]), 32'(ex_rdy));
        chk($sformatf("hresp%0d", d), 32'(hresp[d]), 32'(ex_rsp));
        chk($sformatf("hrdata%0d", d), hrdata[d], ex_dat);
        if (m_left[d] == 1) last_rd[d] = hrdata[d];
        hwdata[d] = (m_left[d] > 0 && !m_err[d] && m_wr[d]) ? m_wdata[d] : $urandom();
        ready = (m_left[d] <= 1);
        if (m_left[d] == 1 && !m_err[d] && m_wr[d]) begin
            for (int b = 0; b < 4; b++)
                if (m_lanes[d][b]) mem_m[d][m_word[d]][8*b +: 8] = m_wdata[d][8*b +: 8];
        end
        took = 1'b0;
        if (use_x && ready) begin
            hsel[d] = x.sel; htrans[d] = x.trans; haddr[d] = x.addr;
            hsize[d] = x.size; hwrite[d] = x.wr;
            took = 1'b1;
        end else begin
            drive_idle(d);
        end
        if (took && x.sel && x.trans[1]) begin
            m_err[d]   = m_illegal(x);
            m_left[d]  = m_err[d] ? 2 : waitc[d] + 1;
            m_wr[d]    = x.wr;
            m_word[d]  = int'((x.addr >> 2) % NW);
            m_lanes[d] = m_lanes_of(x);
            m_wdata[d] = x.wdata;
        end else if (m_left[d] > 0) begin
            m_left[d]--;
        end
    endtask

    task automatic issue(input int d, input xfer_t x);
        bit took;
        int n;
        took = 1'b0;
        n = 0;
        while (!took && n < 10) begin
            cycle(d, x, 1'b1, took);
            n++;
        end
        if (!took) begin
            total++;
            bad++;
            $error("FAIL issue_timeout%0d: observed=stalled required=accepted", d);
        end
    endtask

    task automatic drain(input int d);
        bit   took;
        xfer_t x;
        int   n;
        x = mk(1'b0, 32'd0, 3'd2, 32'd0);
        n = 0;
        while (m_left[d] > 0 && n < 10) begin
            cycle(d, x, 1'b0, took);
            n++;
        end
        cycle(d, x, 1'b0, took);
    endtask

    task automatic read_check(input int d, input logic [31:0] addr,
                              input logic [31:0] exp, input string tag);
        issue(d, mk(1'b0, addr, 3'd2, 32'd0));
        drain(d);
        chk(tag, last_rd[d], exp);
    endtask

    initial begin
        xfer_t x;
        bit    took;
        rst = 2'b11;
        for (int d = 0; d < 2; d++) begin
            m_left[d] = 0; m_err[d] = 1'b0; m_wr[d] = 1'b0; m_word[d] = 0;
            m_lanes[d] = 4'h0; m_wdata[d] = 32'd0; last_rd[d] = 32'd0;
            hwdata[d] = 32'd0;
            drive_idle(d);
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_hreadyout%0d", d), 32'(hreadyout[d]), 32'd1);
            chk($sformatf("rst_hresp%0d", d), 32'(hresp[d]), 32'd0);
            chk($sformatf("rst_hrdata%0d", d), hrdata[d], 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 2'b00;

        // Preload so every word the model reads is known.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < NW; w++) issue(d, mk(1'b1, 32'(w * 4), 3'd2, $urandom()));
            drain(d);
        end

        issue(0, mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        read_check(0, 32'h10, 32'hDEADBEEF, "rd_deadbeef");
        issue(0, mk(1'b1, 32'h20, 3'd2, 32'h11223344));
        issue(0, mk(1'b1, 32'h21, 3'd0, 32'hFFFFAAFF));
        read_check(0, 32'h20, 32'h1122AA44, "rd_byte_merge");
        issue(0, mk(1'b1, 32'h22, 3'd1, 32'h55661234));
        read_check(0, 32'h20, 32'h5566AA44, "rd_half_merge");
        issue(0, mk(1'b1, 32'h00, 3'd2, 32'hCAFEF00D));
`ifdef CM0_AHB_SRAM_ERR_EN
        read_check(0, 32'h02, 32'h00000000, "rd_misaligned");
`else
        read_check(0, 32'h02, 32'hCAFEF00D, "rd_misaligned");
`endif
        read_check(0, 32'h00, 32'hCAFEF00D, "rd_word0");

        issue(1, mk(1'b1, 32'h40, 3'd2, 32'h0BADCAFE));
        issue(1, mk(1'b0, 32'h40, 3'd2, 32'd0));
        issue(1, mk(1'b0, 32'h44, 3'd2, 32'd0));
        read_check(1, 32'h40, 32'h0BADCAFE, "rd_wait2");

        issue(1, mk(1'b1, 32'h40, 3'd2, 32'h12345678));
        cycle(1, x, 1'b0, took);
        @(posedge clk);
        #1 rst[1] = 1'b1;
        #1;
        chk("rstmid_hreadyout", 32'(hreadyout[1]), 32'd1);
        chk("rstmid_hresp", 32'(hresp[1]), 32'd0);
        chk("rstmid_hrdata", hrdata[1], 32'd0);
        m_left[1] = 0;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        read_check(1, 32'h40, 32'h0BADCAFE, "rd_after_reset");

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 200; i++) begin
                x.sel   = ($urandom_range(0, 7) != 0);
                x.trans = 2'($urandom_range(0, 3));
                x.wr    = 1'($urandom_range(0, 1));
                x.size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                x.addr  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 1023))
                                                       : 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0 && x.size <= 3'd2)
                    x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
                x.wdata = $urandom();
                issue(d, x);
                if ($urandom_range(0, 3) == 0) cycle(d, x, 1'b0, took);
            end
            drain(d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
